// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs drained round-robin onto two common data buses.
// Two grants per cycle, registered bus outputs, sticky overflow on dropped pushes.
module cdb_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [N_SRC-1:0]          src_ready,
    input  logic [N_SRC*TAG_W-1:0]    src_tag,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_full,
    output logic                      CDB1_ready,
    output logic [TAG_W-1:0]          CDB1_tag,
    output logic [DATA_W-1:0]         CDB1_data,
    output logic                      CDB2_ready,
    output logic [TAG_W-1:0]          CDB2_tag,
    output logic [DATA_W-1:0]         CDB2_data,
    output logic                      overflow
);
    localparam int EW = TAG_W + DATA_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(N_SRC);

    logic [EW-1:0] mem_q [N_SRC][DEPTH];
    logic [PW-1:0] rd_q [N_SRC];
    logic [PW-1:0] wr_q [N_SRC];
    logic [CW-1:0] cnt_q [N_SRC];
    logic [CW-1:0] cnt_d [N_SRC];
    logic [EW-1:0] head [N_SRC];
    logic [SW-1:0] rr_q, rr_d, g1, g2;
    logic          g1_v, g2_v, ovf_d;
    logic [N_SRC-1:0] pop, push, req, full_now;
    int j;

    function automatic logic [SW-1:0] nxt(input logic [SW-1:0] g);
        return (g == SW'(N_SRC - 1)) ? '0 : g + SW'(1);
    endfunction

    // Scan from rr_q: first non-empty FIFO feeds CDB1, second feeds CDB2.
    always_comb begin
        g1_v = 1'b0;
        g2_v = 1'b0;
        g1   = '0;
        g2   = '0;
        j    = 0;
        for (int k = 0; k < N_SRC; k++) begin
            j = (int'(rr_q) + k) % N_SRC;
            if (cnt_q[j] != '0) begin
                if (!g1_v) begin
                    g1_v = 1'b1;
                    g1   = SW'(j);
                end else if (!g2_v) begin
                    g2_v = 1'b1;
                    g2   = SW'(j);
                end
            end
        end
        rr_d = g2_v ? nxt(g2) : g1_v ? nxt(g1) : rr_q;
    end

    // A full FIFO still accepts a push when its head is popped in the same cycle.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            head[i]     = mem_q[i][rd_q[i]];
            pop[i]      = (g1_v && g1 == SW'(i)) || (g2_v && g2 == SW'(i));
            req[i]      = src_ready[i] && (src_tag[i*TAG_W +: TAG_W] != '0);
            full_now[i] = cnt_q[i] == CW'(DEPTH);
            push[i]     = req[i] && (!full_now[i] || pop[i]);
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
        ovf_d = overflow || |(req & full_now & ~pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q       <= '0;
            src_full   <= '0;
            overflow   <= 1'b0;
            CDB1_ready <= 1'b0;
            CDB1_tag   <= '0;
            CDB1_data  <= '0;
            CDB2_ready <= 1'b0;
            CDB2_tag   <= '0;
            CDB2_data  <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_q[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
                    wr_q[i]           <= wr_q[i] + PW'(1);
                end
                if (pop[i]) rd_q[i] <= rd_q[i] + PW'(1);
                cnt_q[i]    <= cnt_d[i];
                src_full[i] <= cnt_d[i] == CW'(DEPTH);
            end
            rr_q                  <= rr_d;
            overflow              <= ovf_d;
            CDB1_ready            <= g1_v;
            {CDB1_tag, CDB1_data} <= g1_v ? head[g1] : '0;
            CDB2_ready            <= g2_v;
            {CDB2_tag, CDB2_data} <= g2_v ? head[g2] : '0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a queue-based model.
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset, flush;
    logic [N-1:0] src_ready;
    logic [N*TW-1:0] src_tag;
    logic [N*DW-1:0] src_data;
    logic [N-1:0] src_full;
    logic CDB1_ready, CDB2_ready, overflow;
    logic [TW-1:0] CDB1_tag, CDB2_tag;
    logic [DW-1:0] CDB1_data, CDB2_data;

    int checks = 0;
    int passes = 0;

    typedef logic [TW+DW-1:0] ent_t;
    ent_t mq [N][$];
    int rr;
    logic [TW+DW:0] eb1, eb2;
    logic [N-1:0] efull;
    logic eovf;

    cdb_arbiter #(.N_SRC(N), .DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .src_ready(src_ready), .src_tag(src_tag), .src_data(src_data),
        .src_full(src_full),
        .CDB1_ready(CDB1_ready), .CDB1_tag(CDB1_tag), .CDB1_data(CDB1_data),
        .CDB2_ready(CDB2_ready), .CDB2_tag(CDB2_tag), .CDB2_data(CDB2_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [2*(TW+DW+1)+N:0] obs();
        return {CDB1_ready, CDB1_tag, CDB1_data, CDB2_ready, CDB2_tag, CDB2_data, src_full, overflow};
    endfunction

    function automatic logic [2*(TW+DW+1)+N:0] expv();
        return {eb1, eb2, efull, eovf};
    endfunction

    task automatic clear_in();
        reset = 1'b0;
        flush = 1'b0;
        src_ready = '0;
        src_tag = '0;
        src_data = '0;
    endtask

    task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        src_ready[i] = 1'b1;
        src_tag[i*TW +: TW] = t;
        src_data[i*DW +: DW] = d;
    endtask

    // Model: each cycle grant up to two non-empty queues from rr, pop them, then enqueue.
    task automatic step();
        int g [$];
        int s;
        if (reset || flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            rr = 0; eb1 = '0; eb2 = '0; efull = '0; eovf = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                s = (rr + k) % N;
                if (mq[s].size() > 0 && g.size() < 2) g.push_back(s);
            end
            eb1 = '0;
            eb2 = '0;
            if (g.size() > 0) eb1 = {1'b1, mq[g[0]].pop_front()};
            if (g.size() > 1) eb2 = {1'b1, mq[g[1]].pop_front()};
            if (g.size() > 0) rr = (g[g.size()-1] + 1) % N;
            for (int i = 0; i < N; i++)
                if (src_ready[i] && src_tag[i*TW +: TW] != '0) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
                    else eovf = 1'b1;
                end
            for (int i = 0; i < N; i++) efull[i] = mq[i].size() == DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_src(i, TW'(i + 1), $urandom);
        step();
        step();
        checks++;
        if (obs() !== '0) $display("FAIL reset_state got=%h exp=0", obs());
        else passes++;
        clear_in();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs() !== expv() || CDB1_ready || CDB2_ready)
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs(), expv());
            else passes++;
        end
    endtask

    task automatic test_single();
        clear_in();
        set_src(2, 6'h05, 32'hDEADBEEF);
        step();
        clear_in();
        step();
        checks++;
        if ({CDB1_ready, CDB1_tag, CDB1_data, CDB2_ready} !== {1'b1, 6'h05, 32'hDEADBEEF, 1'b0})
            $display("FAIL single_bus got=%b/%h/%h c2=%b exp=1/05/deadbeef c2=0", CDB1_ready, CDB1_tag, CDB1_data, CDB2_ready);
        else passes++;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs() !== expv()) $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs(), expv());
            else passes++;
        end
    endtask

    task automatic test_contention();
        logic [TW-1:0] et1 [3];
        logic [TW-1:0] et2 [3];
        et1 = '{6'd1, 6'd3, 6'd0};
        et2 = '{6'd2, 6'd4, 6'd0};
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, TW'(i + 1), 32'h100 + i);
        step();
        clear_in();
        step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (CDB1_tag !== et1[c] || CDB2_tag !== et2[c] || CDB1_ready !== (et1[c] != 0) || obs() !== expv())
                $display("FAIL contention cyc=%0d got=%h/%h exp=%h/%h", c, CDB1_tag, CDB2_tag, et1[c], et2[c]);
            else passes++;
            step();
        end
    endtask

    task automatic test_fairness();
        int push_at, seen_at;
        do_reset();
        push_at = 3;
        seen_at = -1;
        for (int c = 0; c < 14; c++) begin
            clear_in();
            set_src(0, TW'($urandom_range(1, 8)), $urandom);
            if (c == push_at) set_src(3, 6'd9, 32'h99);
            step();
            if (seen_at < 0 && ((CDB1_ready && CDB1_tag == 6'd9) || (CDB2_ready && CDB2_tag == 6'd9))) seen_at = c;
            checks++;
            if (obs() !== expv()) $display("FAIL fair_model cyc=%0d got=%h exp=%h", c, obs(), expv());
            else passes++;
        end
        checks++;
        if (seen_at < 0 || seen_at - push_at > 3 || overflow !== 1'b0)
            $display("FAIL fairness seen_at=%0d push_at=%0d ovf=%b exp_within=3 ovf=0", seen_at, push_at, overflow);
        else passes++;
    endtask

    task automatic test_overflow();
        logic saw_full1;
        saw_full1 = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            clear_in();
            for (int i = 0; i < N; i++) set_src(i, TW'($urandom_range(1, 63)), $urandom);
            step();
            saw_full1 |= src_full[1];
            checks++;
            if (obs() !== expv()) $display("FAIL ovf_model cyc=%0d got=%h exp=%h", c, obs(), expv());
            else passes++;
        end
        clear_in();
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (overflow !== 1'b1 || !saw_full1 || obs() !== expv())
            $display("FAIL overflow_sticky ovf=%b full1_seen=%b exp ovf=1 full1_seen=1", overflow, saw_full1);
        else passes++;
        do_reset();
        checks++;
        if (overflow !== 1'b0) $display("FAIL overflow_clear got=%b exp=0", overflow);
        else passes++;
    endtask

    task automatic test_flush();
        logic leaked;
        leaked = 1'b0;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            clear_in();
            for (int i = 0; i < 3; i++) set_src(i, TW'(16 + 4*c + i), $urandom);
            step();
        end
        clear_in();
        flush = 1'b1;
        set_src(3, 6'h3F, 32'hF00D);
        step();
        clear_in();
        checks++;
        if (CDB1_ready || CDB2_ready || src_full !== '0 || obs() !== '0)
            $display("FAIL flush_idle got=%h exp=0", obs());
        else passes++;
        for (int c = 0; c < 6; c++) begin
            step();
            leaked |= CDB1_ready | CDB2_ready;
        end
        checks++;
        if (leaked || obs() !== expv()) $display("FAIL flush_leak leaked=%b exp=0", leaked);
        else passes++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            clear_in();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) set_src(i, TW'($urandom_range(0, 63)), $urandom);
            flush = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if (obs() !== expv() || (CDB1_ready && CDB2_ready && CDB1_tag == CDB2_tag && CDB1_tag != 0 && eb1[TW+DW-1 -: TW] != eb2[TW+DW-1 -: TW])) begin
                if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", c, obs(), expv());
                bad++;
            end else passes++;
        end
    endtask

    initial begin
        clear_in();
        rr = 0; eb1 = '0; eb2 = '0; efull = '0; eovf = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_overflow();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
